// File: rtl/cmd_proc_tx.sv
// cmd_proc_tx: builds and serialises one 34-word command frame onto a 16-bit
// GTX TX lane (data + 2-bit K-control), with an idle comma gap between frames.
// Optional build macro: CMD_PROC_TX_CSUM_ERR_INJ_EN adds the err_inj input, which
// corrupts bit 0 of the transmitted checksum for receiver rejection testing.
module cmd_proc_tx #(
  parameter int          IDLE_GAP = 4,
  parameter logic [15:0] K_WORD   = 16'h02BC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_req,
  output logic        cmd_ack,
  input  logic [15:0] cmd_opcode,
  input  logic [31:0] cmd_second,
  input  logic [31:0] cmd_microsecond,
  input  logic [15:0] cmd_star_image_send,
  input  logic [15:0] cmd_send_freq,
  input  logic [15:0] cmd_tdi_time,
  input  logic [15:0] cmd_tdi_level,
  input  logic [15:0] cmd_spot_send,
`ifdef CMD_PROC_TX_CSUM_ERR_INJ_EN
  input  logic        err_inj,
`endif
  output logic [15:0] TX_DATA,
  output logic [1:0]  TXCTRL,
  output logic        tx_busy,
  output logic        frame_done,
  output logic        csum_ovf,
  output logic [15:0] frame_seq
);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CSUM, TAIL, GAP} state_t;

  // state is the phase of the word that goes onto the lane at the next edge;
  // idx is that word's index within the frame
  state_t      state_q, state_n;
  logic [5:0]  idx_q, idx_n;
  logic [3:0]  gap_q, gap_n;
  logic [15:0] sum_q, sum_n;
  logic        carry_q, carry_n;
  logic [15:0] seq_n;
  logic [15:0] data_n;
  logic [1:0]  ctrl_n;
  logic        ack_n, busy_n, done_n, ovf_n;
  logic        take;
  logic [15:0] pay_word;
  logic [16:0] add17;
  logic [15:0] csum_word;

  logic [15:0] op_q, star_q, freq_q, tdi_time_q, tdi_level_q, spot_q;
  logic [31:0] sec_q, usec_q;

`ifdef CMD_PROC_TX_CSUM_ERR_INJ_EN
  logic err_q;

  // Remember the injection request of this frame; it only flips checksum bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    err_q <= 1'b0;
    else if (take) err_q <= err_inj;
  end

  assign csum_word = sum_q ^ {15'd0, err_q};
`else
  assign csum_word = sum_q;
`endif

  // Parameter set captured on the ack edge so later input changes cannot leak in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      sec_q       <= '0;
      usec_q      <= '0;
      star_q      <= '0;
      freq_q      <= '0;
      tdi_time_q  <= '0;
      tdi_level_q <= '0;
      spot_q      <= '0;
    end else if (take) begin
      op_q        <= cmd_opcode;
      sec_q       <= cmd_second;
      usec_q      <= cmd_microsecond;
      star_q      <= cmd_star_image_send;
      freq_q      <= cmd_send_freq;
      tdi_time_q  <= cmd_tdi_time;
      tdi_level_q <= cmd_tdi_level;
      spot_q      <= cmd_spot_send;
    end
  end

  // Payload word selection for indices 3..29; unlisted indices are zero padding
  always_comb begin
    pay_word = '0;
    case (idx_q)
      6'd3:    pay_word = frame_seq;
      6'd4:    pay_word = op_q;
      6'd7:    pay_word = sec_q[31:16];
      6'd8:    pay_word = sec_q[15:0];
      6'd9:    pay_word = usec_q[31:16];
      6'd10:   pay_word = usec_q[15:0];
      6'd11:   pay_word = star_q;
      6'd12:   pay_word = freq_q;
      6'd13:   pay_word = tdi_time_q;
      6'd14:   pay_word = tdi_level_q;
      6'd15:   pay_word = spot_q;
      default: pay_word = '0;
    endcase
  end

  assign add17 = {1'b0, sum_q} + {1'b0, pay_word};

  // Next-state and next-output logic; the lane idles on K_WORD unless a data word is due
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    gap_n   = gap_q;
    sum_n   = sum_q;
    carry_n = carry_q;
    seq_n   = frame_seq;
    data_n  = K_WORD;
    ctrl_n  = 2'b01;
    ack_n   = 1'b0;
    busy_n  = tx_busy;
    done_n  = 1'b0;
    ovf_n   = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_req && gap_q == 4'd0) begin
          take    = 1'b1;
          ack_n   = 1'b1;
          busy_n  = 1'b1;
          seq_n   = frame_seq + 16'd1;
          sum_n   = '0;
          carry_n = 1'b0;
          idx_n   = 6'd1;
          state_n = HDR;
        end
      end
      HDR: begin
        ctrl_n = 2'b00;
        data_n = (idx_q == 6'd1) ? 16'h2410 : 16'h1984;
        idx_n  = idx_q + 6'd1;
        if (idx_q == 6'd2) state_n = PAYLOAD;
      end
      PAYLOAD: begin
        ctrl_n  = 2'b00;
        data_n  = pay_word;
        sum_n   = add17[15:0];
        carry_n = carry_q | add17[16];
        idx_n   = idx_q + 6'd1;
        if (idx_q == 6'd29) state_n = CSUM;
      end
      CSUM: begin
        ctrl_n  = 2'b00;
        data_n  = csum_word;
        idx_n   = 6'd31;
        state_n = TAIL;
      end
      TAIL: begin
        ctrl_n = 2'b00;
        data_n = (idx_q == 6'd31) ? 16'hDBEF : 16'hE67B;
        idx_n  = idx_q + 6'd1;
        if (idx_q == 6'd32) begin
          gap_n   = 4'(IDLE_GAP - 1);
          state_n = GAP;
        end
      end
      GAP: begin
        if (idx_q == 6'd33) begin
          done_n = 1'b1;
          ovf_n  = carry_q;
          idx_n  = 6'd0;
        end
        if (gap_q == 4'd0) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          gap_n = gap_q - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset puts the lane straight back onto K_WORD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      frame_seq  <= '0;
      TX_DATA    <= K_WORD;
      TXCTRL     <= 2'b01;
      cmd_ack    <= 1'b0;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      csum_ovf   <= 1'b0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      gap_q      <= gap_n;
      sum_q      <= sum_n;
      carry_q    <= carry_n;
      frame_seq  <= seq_n;
      TX_DATA    <= data_n;
      TXCTRL     <= ctrl_n;
      cmd_ack    <= ack_n;
      tx_busy    <= busy_n;
      frame_done <= done_n;
      csum_ovf   <= ovf_n;
    end
  end

endmodule

// File: tb/tb_cmd_proc_tx.sv
// tb_cmd_proc_tx: directed test of cmd_proc_tx frame contents, checksum,
// handshake timing, back-to-back spacing and asynchronous reset mid-frame.
module tb_cmd_proc_tx;

  localparam logic [15:0] K = 16'h02BC;

  logic        clk;
  logic        rst_n;
  logic        cmd_req;
  logic        cmd_ack;
  logic [15:0] cmd_opcode;
  logic [31:0] cmd_second;
  logic [31:0] cmd_microsecond;
  logic [15:0] cmd_star_image_send;
  logic [15:0] cmd_send_freq;
  logic [15:0] cmd_tdi_time;
  logic [15:0] cmd_tdi_level;
  logic [15:0] cmd_spot_send;
`ifdef CMD_PROC_TX_CSUM_ERR_INJ_EN
  logic        err_inj;
`endif
  logic [15:0] TX_DATA;
  logic [1:0]  TXCTRL;
  logic        tx_busy;
  logic        frame_done;
  logic        csum_ovf;
  logic [15:0] frame_seq;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [15:0] got_data [34];
  logic [1:0]  got_ctrl [34];
  logic        got_done [34];
  logic        got_ovf  [34];
  logic [15:0] exp_data [34];
  logic [1:0]  exp_ctrl [34];

  cmd_proc_tx #(.IDLE_GAP(4), .K_WORD(16'h02BC)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cmd_req             (cmd_req),
    .cmd_ack             (cmd_ack),
    .cmd_opcode          (cmd_opcode),
    .cmd_second          (cmd_second),
    .cmd_microsecond     (cmd_microsecond),
    .cmd_star_image_send (cmd_star_image_send),
    .cmd_send_freq       (cmd_send_freq),
    .cmd_tdi_time        (cmd_tdi_time),
    .cmd_tdi_level       (cmd_tdi_level),
    .cmd_spot_send       (cmd_spot_send),
`ifdef CMD_PROC_TX_CSUM_ERR_INJ_EN
    .err_inj             (err_inj),
`endif
    .TX_DATA             (TX_DATA),
    .TXCTRL              (TXCTRL),
    .tx_busy             (tx_busy),
    .frame_done          (frame_done),
    .csum_ovf            (csum_ovf),
    .frame_seq           (frame_seq)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] op, input logic [31:0] sec, input logic [31:0] us,
                                input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                                input logic [15:0] d, input logic [15:0] e);
    cmd_opcode          = op;
    cmd_second          = sec;
    cmd_microsecond     = us;
    cmd_star_image_send = a;
    cmd_send_freq       = b;
    cmd_tdi_time        = c;
    cmd_tdi_level       = d;
    cmd_spot_send       = e;
    cmd_req             = 1'b1;
  endtask

  // Reference frame straight from the frame layout
  task automatic build_expected(input logic [15:0] seq, input logic [15:0] op, input logic [31:0] sec,
                                input logic [31:0] us, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d, input logic [15:0] e);
    logic [31:0] total;
    for (int i = 0; i < 34; i++) begin
      exp_data[i] = 16'h0000;
      exp_ctrl[i] = 2'b00;
    end
    exp_data[0]  = K;            exp_ctrl[0] = 2'b01;
    exp_data[1]  = 16'h2410;
    exp_data[2]  = 16'h1984;
    exp_data[3]  = seq;
    exp_data[4]  = op;
    exp_data[7]  = sec[31:16];
    exp_data[8]  = sec[15:0];
    exp_data[9]  = us[31:16];
    exp_data[10] = us[15:0];
    exp_data[11] = a;
    exp_data[12] = b;
    exp_data[13] = c;
    exp_data[14] = d;
    exp_data[15] = e;
    total = 32'd0;
    for (int i = 3; i <= 29; i++) total = total + {16'd0, exp_data[i]};
    exp_data[30] = total[15:0];
    exp_data[31] = 16'hDBEF;
    exp_data[32] = 16'hE67B;
    exp_data[33] = K;            exp_ctrl[33] = 2'b01;
  endtask

  // Waits (bounded) for cmd_ack and records the 34 lane words from the ack cycle on
  task automatic capture_frame(input bit scramble);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (cmd_ack === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_output("ack_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 34; i++) begin
      if (i > 0) @(negedge clk);
      got_data[i] = TX_DATA;
      got_ctrl[i] = TXCTRL;
      got_done[i] = frame_done;
      got_ovf[i]  = csum_ovf;
      if (i == 0) begin
        cmd_req = 1'b0;
        if (scramble) apply_stimulus(16'hFFFF, 32'h5555_AAAA, 32'h1234_5678, 16'h1111,
                                     16'h2222, 16'h3333, 16'h4444, 16'h5555);
        cmd_req = 1'b0;
      end
    end
  endtask

  task automatic verify_frame(input string name, input logic [15:0] hand_seq,
                              input logic [15:0] hand_csum, input logic hand_ovf);
    int mism;
    int done_idx;
    int done_cnt;
    mism = 0;
    done_idx = 99;
    done_cnt = 0;
    for (int i = 0; i < 34; i++) begin
      if (got_data[i] !== exp_data[i] || got_ctrl[i] !== exp_ctrl[i]) mism++;
      if (got_done[i] === 1'b1) begin
        done_cnt++;
        if (done_idx == 99) done_idx = i;
      end
    end
    check_output({name, "_word_mismatches"}, mism, 0);
    check_output({name, "_seq_word"}, {16'd0, got_data[3]}, {16'd0, hand_seq});
    check_output({name, "_csum_word"}, {16'd0, got_data[30]}, {16'd0, hand_csum});
    check_output({name, "_tail"}, {got_data[31], got_data[32]}, 32'hDBEF_E67B);
    check_output({name, "_close_k"}, {14'd0, got_ctrl[33], got_data[33]}, {14'd0, 2'b01, K});
    check_output({name, "_done_idx"}, done_idx, 33);
    check_output({name, "_done_cnt"}, done_cnt, 1);
    check_output({name, "_csum_ovf"}, {31'd0, got_ovf[33]}, {31'd0, hand_ovf});
  endtask

  // Bounded wait for the transmitter to go idle again
  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (tx_busy === 1'b0) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) check_output("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  // Directed sequence
  initial begin
    int bad;
    int cyc;
    int kcnt;
    bit after_tail;
    bit seen;

    rst_n   = 1'b0;
    cmd_req = 1'b0;
`ifdef CMD_PROC_TX_CSUM_ERR_INJ_EN
    err_inj = 1'b0;
`endif
    apply_stimulus(16'h0, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    cmd_req = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_lane", {14'd0, TXCTRL, TX_DATA}, {14'd0, 2'b01, K});
    check_output("reset_flags", {28'd0, cmd_ack, tx_busy, frame_done, csum_ovf}, 32'd0);
    check_output("reset_seq", {16'd0, frame_seq}, 32'd0);
    rst_n = 1'b1;

    // Idle lane with no request
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (TX_DATA !== K || TXCTRL !== 2'b01 || tx_busy !== 1'b0 || frame_seq !== 16'd0) bad++;
    end
    check_output("idle_lane_bad_cycles", bad, 0);

    // Config frame; inputs scrambled after ack must not leak in. 1+1+1+2+3+4+5+6+7 = 0x1E
    apply_stimulus(16'h0001, 32'h0000_0001, 32'h0000_0002, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7);
    build_expected(16'd1, 16'h0001, 32'h0000_0001, 32'h0000_0002, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7);
    capture_frame(1'b1);
    verify_frame("config", 16'h0001, 16'h001E, 1'b0);
    check_output("config_frame_seq", {16'd0, frame_seq}, 32'd1);
    wait_idle();

    // Shutdown frame: 0xA5A5 + seq 2
    apply_stimulus(16'hA5A5, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    build_expected(16'd2, 16'hA5A5, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    capture_frame(1'b0);
    verify_frame("shutdown", 16'h0002, 16'hA5A7, 1'b0);
    check_output("shutdown_frame_seq", {16'd0, frame_seq}, 32'd2);
    wait_idle();

    // Overflow: 3 + 1 + 0xFFFF + 0xFFFF = 0x20002
    apply_stimulus(16'h0001, 32'hFFFF_FFFF, 32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    build_expected(16'd3, 16'h0001, 32'hFFFF_FFFF, 32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    capture_frame(1'b0);
    verify_frame("overflow", 16'h0003, 16'h0002, 1'b1);
    wait_idle();

    // Back-to-back: request held; the closing K plus IDLE_GAP-1 idle K words precede the
    // ack cycle (which carries the next frame's opening K)
    apply_stimulus(16'h0001, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (cmd_ack === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("b2b_first_ack_seen", {31'd0, seen}, 32'd1);
    cyc = 0;
    kcnt = 0;
    after_tail = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      cyc++;
      if (cmd_ack === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (TX_DATA === 16'hE67B && TXCTRL === 2'b00) after_tail = 1'b1;
      else if (after_tail && TX_DATA === K && TXCTRL === 2'b01) kcnt++;
    end
    cmd_req = 1'b0;
    check_output("b2b_second_ack_seen", {31'd0, seen}, 32'd1);
    check_output("b2b_ack_spacing", cyc, 37);
    check_output("b2b_gap_k_words", kcnt, 4);
    check_output("b2b_ack_word_k", {14'd0, TXCTRL, TX_DATA}, {14'd0, 2'b01, K});
    @(negedge clk);
    check_output("b2b_next_hdr", {14'd0, TXCTRL, TX_DATA}, {14'd0, 2'b00, 16'h2410});
    check_output("b2b_frame_seq", {16'd0, frame_seq}, 32'd5);
    wait_idle();

    // Asynchronous reset while word 12 is on the lane
    apply_stimulus(16'h0001, 32'h0, 32'h0, 16'h0, 16'h0BEE, 16'h0, 16'h0, 16'h0);
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (cmd_ack === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("rst_frame_ack_seen", {31'd0, seen}, 32'd1);
    cmd_req = 1'b0;
    repeat (12) @(negedge clk);
    check_output("rst_frame_word12", {16'd0, TX_DATA}, 32'h0000_0BEE);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_output("midframe_reset_lane", {14'd0, TXCTRL, TX_DATA}, {14'd0, 2'b01, K});
    check_output("midframe_reset_busy", {31'd0, tx_busy}, 32'd0);
    check_output("midframe_reset_seq", {16'd0, frame_seq}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fresh frame after reset restarts the sequence at 1: 1 + 0x00C0 + 0x0003 = 0x00C4
    apply_stimulus(16'h00C0, 32'h0, 32'h0000_0003, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    build_expected(16'd1, 16'h00C0, 32'h0, 32'h0000_0003, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    capture_frame(1'b1);
    verify_frame("post_reset", 16'h0001, 16'h00C4, 1'b0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
